// File: rtl/obi_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential OBI word reads and queues the
// responses in a small FIFO, discarding in-flight data on a control transfer.
module obi_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_err_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  output logic        obi_rready_o,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             stale_q, stale_d;
  logic [31:0]      stale_addr_q, stale_addr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] mem_data_q [DEPTH];
  logic [31:0] mem_addr_q [DEPTH];
  logic        mem_err_q  [DEPTH];

  logic [PTR_W-1:0] fifo_count;
  logic [SUM_W-1:0] inflight_sum;
  logic             can_issue;
  logic             gnt_fire;
  logic             rsp_fire;
  logic             push;
  logic             pop;
  logic [31:0]      rsp_addr;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^flush_addr_i[1:0];

  assign fifo_count   = wr_ptr_q - rd_ptr_q;
  assign inflight_sum = SUM_W'(outstanding_q) + SUM_W'(fifo_count);
  // Reserving a FIFO slot per outstanding read means a response never stalls.
  assign can_issue    = (outstanding_q < CNT_W'(MAX_OUTSTANDING)) &&
                        (inflight_sum < SUM_W'(DEPTH));

  // A stalled request that was overtaken by a flush keeps its address until granted.
  assign obi_req_o   = !rst_i && (stale_q || can_issue);
  assign obi_addr_o  = stale_q ? stale_addr_q : fetch_addr_q;
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = 4'b1111;
  assign obi_wdata_o = 32'h0000_0000;
  assign obi_rready_o = 1'b1;

  // Handshakes: a request transfers when req&gnt are high on a rising edge; a
  // response when rvalid is high; the consumer takes the head when valid&ready.
  assign gnt_fire = obi_req_o && obi_gnt_i;
  assign rsp_fire = obi_rvalid_i && (outstanding_q != '0);
  assign push     = rsp_fire && !flush_i && (discard_q == '0);
  assign pop      = instr_valid_o && instr_ready_i;

  // Responses return in order, so the oldest live read sits that many words behind.
  assign rsp_addr = fetch_addr_q - 32'({outstanding_q, 2'b00});

  assign instr_valid_o = (wr_ptr_q != rd_ptr_q);
  assign instr_rdata_o = mem_data_q[rd_ptr_q[IDX_W-1:0]];
  assign instr_addr_o  = mem_addr_q[rd_ptr_q[IDX_W-1:0]];
  assign instr_err_o   = mem_err_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    stale_d       = stale_q;
    stale_addr_d  = stale_addr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    case ({gnt_fire, rsp_fire})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (gnt_fire && !stale_q) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end

    if (rsp_fire && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
    if (gnt_fire && stale_q) begin
      stale_d   = 1'b0;
      discard_d = discard_d + CNT_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Everything granted so far, including this cycle's grant, is pre-flush.
    if (flush_i) begin
      fetch_addr_d = {flush_addr_i[31:2], 2'b00};
      discard_d    = outstanding_d;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      if (obi_req_o && !obi_gnt_i) begin
        stale_d      = 1'b1;
        stale_addr_d = obi_addr_o;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_addr_q  <= {BOOT_ADDR[31:2], 2'b00};
      outstanding_q <= '0;
      discard_q     <= '0;
      stale_q       <= 1'b0;
      stale_addr_q  <= 32'h0000_0000;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      stale_q       <= stale_d;
      stale_addr_q  <= stale_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q[IDX_W-1:0]] <= obi_rdata_i;
      mem_addr_q[wr_ptr_q[IDX_W-1:0]] <= rsp_addr;
      mem_err_q[wr_ptr_q[IDX_W-1:0]]  <= obi_err_i;
    end
  end

endmodule

// File: tb/tb_obi_prefetch_buffer.sv
// Directed bench for obi_prefetch_buffer: an in-order OBI memory answers one
// cycle after grant with data = ~addr; each step checks hand-computed values.
module tb_obi_prefetch_buffer;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_err_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic        obi_rready_o;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic        rsp_en;
  logic [31:0] err_addr;
  logic [31:0] pend_q[$];
  logic [31:0] rsp_a;
  logic [31:0] exp_q[$];

  obi_prefetch_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .flush_addr_i  (flush_addr_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o),
    .instr_err_o   (instr_err_o),
    .obi_req_o     (obi_req_o),
    .obi_gnt_i     (obi_gnt_i),
    .obi_addr_o    (obi_addr_o),
    .obi_we_o      (obi_we_o),
    .obi_be_o      (obi_be_o),
    .obi_wdata_o   (obi_wdata_o),
    .obi_rvalid_i  (obi_rvalid_i),
    .obi_rready_o  (obi_rready_o),
    .obi_rdata_i   (obi_rdata_i),
    .obi_err_i     (obi_err_i)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: records a grant just before the edge, answers in order one
  // response per cycle starting the cycle after the grant (while rsp_en=1).
  initial begin
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = 32'h0;
    obi_err_i    = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (obi_req_o && obi_gnt_i) pend_q.push_back(obi_addr_o);
      @(posedge clk);
      #1;
      if (rsp_en && (pend_q.size() > 0)) begin
        rsp_a        = pend_q.pop_front();
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = ~rsp_a;
        obi_err_i    = (rsp_a == err_addr);
      end else begin
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = 32'h0;
        obi_err_i    = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: hold reset two cycles, then release with the given grant/ready/response setup.
  task automatic release_rst(input logic gnt, input logic rdy, input logic ren);
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    obi_gnt_i     = 1'b0;
    instr_ready_i = 1'b0;
    rsp_en        = 1'b0;
    pend_q.delete();
    cyc(2);
    obi_gnt_i     = gnt;
    instr_ready_i = rdy;
    rsp_en        = ren;
    rst_i         = 1'b0;
    #1;
    chk("boot_req", 32'(obi_req_o), 32'h1);
    chk("boot_addr", obi_addr_o, 32'h80);
  endtask

  initial begin
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    flush_addr_i  = 32'h0;
    instr_ready_i = 1'b0;
    obi_gnt_i     = 1'b1;
    rsp_en        = 1'b0;
    err_addr      = 32'hFFFF_FFFF;
    cyc(2);
    chk("rst_req", 32'(obi_req_o), 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("tie_be", 32'(obi_be_o), 32'hF);
    chk("tie_we", 32'(obi_we_o), 32'h0);
    chk("tie_wdata", obi_wdata_o, 32'h0);
    chk("tie_rready", 32'(obi_rready_o), 32'h1);

    // Sequential fetch, consumer always ready, error on the second word
    err_addr = 32'h84;
    release_rst(1'b1, 1'b1, 1'b1);
    cyc(1);
    chk("seq_req1", 32'(obi_req_o), 32'h1);
    chk("seq_addr1", obi_addr_o, 32'h84);
    cyc(1);
    chk("seq_addr2", obi_addr_o, 32'h88);
    chk("seq_valid", 32'(instr_valid_o), 32'h1);
    chk("seq_head0", instr_addr_o, 32'h80);
    chk("seq_data0", instr_rdata_o, ~32'h80);
    chk("seq_err0", 32'(instr_err_o), 32'h0);
    cyc(1);
    chk("seq_head1", instr_addr_o, 32'h84);
    chk("seq_err1", 32'(instr_err_o), 32'h1);
    chk("seq_addr3", obi_addr_o, 32'h8C);
    cyc(1);
    chk("seq_head2", instr_addr_o, 32'h88);
    chk("seq_err2", 32'(instr_err_o), 32'h0);
    err_addr = 32'hFFFF_FFFF;

    // Backpressure: buffer fills to DEPTH and requests stop
    release_rst(1'b1, 1'b0, 1'b1);
    cyc(4);
    chk("bp_req_sum4a", 32'(obi_req_o), 32'h0);
    cyc(2);
    chk("bp_req_sum4b", 32'(obi_req_o), 32'h0);
    chk("bp_full_head", instr_addr_o, 32'h80);
    instr_ready_i = 1'b1;
    cyc(1);
    chk("bp_head1", instr_addr_o, 32'h84);
    chk("bp_req_again", 32'(obi_req_o), 32'h1);
    chk("bp_next_addr", obi_addr_o, 32'h90);
    exp_q = {32'h88, 32'h8C, 32'h90, 32'h94};
    while (exp_q.size() > 0) begin
      cyc(1);
      chk("bp_drain_head", instr_addr_o, exp_q.pop_front());
      chk("bp_drain_valid", 32'(instr_valid_o), 32'h1);
    end

    // Flush with two reads outstanding
    release_rst(1'b1, 1'b1, 1'b0);
    cyc(2);
    chk("fl_req_max", 32'(obi_req_o), 32'h0);
    flush_i      = 1'b1;
    flush_addr_i = 32'h203;
    cyc(1);
    flush_i = 1'b0;
    rsp_en  = 1'b1;
    chk("fl_valid0", 32'(instr_valid_o), 32'h0);
    chk("fl_req0", 32'(obi_req_o), 32'h0);
    cyc(1);
    chk("fl_valid1", 32'(instr_valid_o), 32'h0);
    cyc(1);
    chk("fl_valid2", 32'(instr_valid_o), 32'h0);
    chk("fl_req_new", 32'(obi_req_o), 32'h1);
    chk("fl_addr_new", obi_addr_o, 32'h200);
    cyc(1);
    chk("fl_valid3", 32'(instr_valid_o), 32'h0);
    cyc(1);
    chk("fl_valid4", 32'(instr_valid_o), 32'h1);
    chk("fl_head", instr_addr_o, 32'h200);
    chk("fl_data", instr_rdata_o, ~32'h200);

    // Flush while a request is stalled without grant
    release_rst(1'b0, 1'b1, 1'b1);
    cyc(1);
    chk("st_req_c1", 32'(obi_req_o), 32'h1);
    chk("st_addr_c1", obi_addr_o, 32'h80);
    flush_i      = 1'b1;
    flush_addr_i = 32'h200;
    cyc(1);
    flush_i = 1'b0;
    chk("st_req_c2", 32'(obi_req_o), 32'h1);
    chk("st_addr_c2", obi_addr_o, 32'h80);
    cyc(1);
    chk("st_addr_c3", obi_addr_o, 32'h80);
    obi_gnt_i = 1'b1;
    cyc(1);
    chk("st_req_new", 32'(obi_req_o), 32'h1);
    chk("st_addr_new", obi_addr_o, 32'h200);
    cyc(1);
    chk("st_valid_drop", 32'(instr_valid_o), 32'h0);
    cyc(1);
    chk("st_valid", 32'(instr_valid_o), 32'h1);
    chk("st_head", instr_addr_o, 32'h200);

    // Reset with two reads outstanding; late responses must be ignored
    release_rst(1'b1, 1'b0, 1'b1);
    cyc(1);
    rsp_en = 1'b0;
    cyc(2);
    chk("mr_req_pre", 32'(obi_req_o), 32'h0);
    chk("mr_valid_pre", 32'(instr_valid_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk("mr_req_rst", 32'(obi_req_o), 32'h0);
    chk("mr_valid_rst", 32'(instr_valid_o), 32'h0);
    cyc(1);
    obi_gnt_i = 1'b0;
    rsp_en    = 1'b1;
    rst_i     = 1'b0;
    #1;
    chk("mr_req_boot", 32'(obi_req_o), 32'h1);
    chk("mr_addr_boot", obi_addr_o, 32'h80);
    cyc(1);
    chk("mr_valid_late0", 32'(instr_valid_o), 32'h0);
    cyc(1);
    chk("mr_valid_late1", 32'(instr_valid_o), 32'h0);
    cyc(1);
    chk("mr_valid_late2", 32'(instr_valid_o), 32'h0);
    obi_gnt_i = 1'b1;
    cyc(1);
    chk("mr_addr_next", obi_addr_o, 32'h84);
    cyc(1);
    chk("mr_valid", 32'(instr_valid_o), 32'h1);
    chk("mr_head", instr_addr_o, 32'h80);
    chk("mr_data", instr_rdata_o, ~32'h80);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/obi_prefetch_buffer.md
OBI_PREFETCH_BUFFER -- requirements
Module: obi_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, >= 2.
REQ-002 Parameter MAX_OUTSTANDING, default 2: maximum granted-but-unanswered OBI reads; 1..DEPTH.
REQ-003 Parameter BOOT_ADDR, default 32'h0000_0080: first fetch address; bits [1:0] are ignored.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 flush_i  in  1  control transfer; discard all buffered and in-flight data.
REQ-007 flush_addr_i  in  32  new fetch address, sampled when flush_i=1; bits [1:0] are ignored.
REQ-008 instr_valid_o  out  1  the FIFO head is valid.
REQ-009 instr_ready_i  in  1  the consumer accepts the head.
REQ-010 instr_rdata_o  out  32  head instruction word.
REQ-011 instr_addr_o  out  32  word address of the head.
REQ-012 instr_err_o  out  1  OBI error flag of the head.
REQ-013 obi_req_o  out  1  OBI request.
REQ-014 obi_gnt_i  in  1  OBI grant.
REQ-015 obi_addr_o  out  32  OBI address, word aligned.
REQ-016 obi_we_o, obi_be_o, obi_wdata_o  out  1/4/32  tied to 0, 4'b1111, 0.
REQ-017 obi_rvalid_i  in  1  response valid.
REQ-018 obi_rready_o  out  1  tied to 1.
REQ-019 obi_rdata_i  in  32  response data.
REQ-020 obi_err_i  in  1  response error.

Function
REQ-021 The fetch address register shall advance by 4 on each grant; instr_addr_o shall hold the fetch address recorded at that grant.
REQ-022 obi_req_o shall assert when outstanding < MAX_OUTSTANDING and (outstanding + fifo_count) < DEPTH, so every response has a guaranteed FIFO slot.
REQ-023 While obi_req_o=1 and obi_gnt_i=0, obi_req_o and obi_addr_o shall hold stable to the next cycle, including across flush_i.
REQ-024 The outstanding counter shall change by +1 on grant and -1 on rvalid; both in one cycle shall leave it unchanged.
REQ-025 A non-discarded response shall be written to the FIFO with its data, address and error; instr_valid_o shall rise the cycle after rvalid (latency 1, no bypass).
REQ-026 A pop shall occur when instr_valid_o and instr_ready_i are both 1; push and pop in the same cycle shall be allowed, including at full.
REQ-027 On flush_i:
  - clear the FIFO next cycle;
  - set discard_cnt to the outstanding count after that cycle's grant and response;
  - drop a response arriving in the flush cycle;
  - load the fetch address with {flush_addr_i[31:2], 2'b00}.
REQ-028 A request pending without grant at flush_i is stale: its grant shall increment discard_cnt, and the flush address shall be issued only after that grant.
REQ-029 While discard_cnt > 0, responses shall decrement it and shall not be written to the FIFO.
REQ-030 instr_valid_o shall be 0 in the cycle after flush_i until a post-flush response arrives.
REQ-031 A flush_i arriving while discard_cnt > 0 shall recompute discard_cnt per REQ-027 and shall not accumulate.
REQ-032 FIFO pointers shall wrap modulo DEPTH; full and empty shall be distinguished by an extra pointer bit or a count.

Reset
REQ-033 While rst_i=1:
  - obi_req_o=0;
  - instr_valid_o=0;
  - FIFO, outstanding and discard_cnt are 0;
  - fetch address = {BOOT_ADDR[31:2], 2'b00}.
REQ-034 The first request shall be issued in the first cycle after rst_i deasserts; reset mid-transaction shall abandon all in-flight state, and late responses shall be ignored because outstanding=0.

Verification
REQ-035 Reset release with gnt=1 and rvalid one cycle after each grant -> addresses 0x80, 0x84, 0x88 issued on consecutive cycles; instr_addr_o sequence matches.
REQ-036 instr_ready_i=0, DEPTH=4, MAX_OUTSTANDING=2 -> at most 4 words are buffered and obi_req_o stays 0 while outstanding + count = 4.
REQ-037 Two reads outstanding, flush_i with flush_addr_i=0x203 -> both responses are dropped, the next address is 0x200, and instr_addr_o=0x200 is the first popped entry.
REQ-038 Request stalled with gnt=0 for 3 cycles and flush_i in cycle 1 -> address held stable, granted, response discarded, then the 0x200 request follows.
REQ-039 obi_err_i=1 on the second response -> instr_err_o=1 only with the second word.
REQ-040 rst_i asserted with 2 reads outstanding -> outputs go to 0 immediately; after release, fetching restarts at BOOT_ADDR.
